// File: rtl/alu_pkg.sv
// Shared ALU definitions for the decoder, operand issue stage and ALU.
// Pure declarations; no logic, no latency, no flow control.
package alu_pkg;

    localparam int DataWidth   = 32;
    localparam int SelectWidth = 4;
    localparam int RegCount    = 32;

    typedef enum logic [SelectWidth-1:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        MUL = 4'd2,
        AND = 4'd3,
        OR  = 4'd4,
        XOR = 4'd5,
        NOT = 4'd6,
        SLL = 4'd7,
        SRL = 4'd8
    } alu_op_t;

endpackage

// File: rtl/register_file.sv
// Integer register file: two combinational read ports, one write port, x0 fixed at zero.
// Reads are zero latency with write-first bypass; writes land on the next edge.
// No backpressure: a write strobe is always taken.
module register_file
    import alu_pkg::*;
#(
    parameter int dataWidth = DataWidth,
    parameter int regCount  = RegCount,
    parameter int addrWidth = $clog2(regCount)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [addrWidth-1:0] rs1Addr,
    input  logic [addrWidth-1:0] rs2Addr,
    output logic [dataWidth-1:0] rs1Data,
    output logic [dataWidth-1:0] rs2Data,
    input  logic                 wbValid,
    input  logic [addrWidth-1:0] wbAddr,
    input  logic [dataWidth-1:0] wbData
);

    logic [dataWidth-1:0] regs [regCount];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < regCount; i++) begin
                regs[i] <= '0;
            end
        end else if (wbValid && wbAddr != '0) begin
            regs[wbAddr] <= wbData;
        end
    end

    // A write-back in flight is visible to readers in the same cycle.
    always_comb begin
        rs1Data = '0;
        if (rs1Addr != '0) begin
            rs1Data = (wbValid && wbAddr == rs1Addr) ? wbData : regs[rs1Addr];
        end
    end

    always_comb begin
        rs2Data = '0;
        if (rs2Addr != '0) begin
            rs2Data = (wbValid && wbAddr == rs2Addr) ? wbData : regs[rs2Addr];
        end
    end

endmodule

// File: rtl/alu_operand_issue.sv
// Operand issue stage: reads sources, picks reg/imm operand B, scoreboards pending writes.
// Latency 1 cycle from accept to registered bundle at the ALU.
// Stalls on RAW/WAW hazards or when a held bundle is not yet consumed (valid/ready).
module alu_operand_issue
    import alu_pkg::*;
#(
    parameter int dataWidth   = DataWidth,
    parameter int selectWidth = SelectWidth,
    parameter int regCount    = RegCount,
    parameter int addrWidth   = $clog2(regCount)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instValid,
    output logic                   instReady,
    input  logic [addrWidth-1:0]   rs1Addr,
    input  logic [addrWidth-1:0]   rs2Addr,
    input  logic [addrWidth-1:0]   rdAddr,
    input  logic                   useImm,
    input  logic [dataWidth-1:0]   immediate,
    input  logic [selectWidth-1:0] opSelect,
    output logic                   issueValid,
    input  logic                   issueReady,
    output logic [dataWidth-1:0]   inputA,
    output logic [dataWidth-1:0]   inputB,
    output logic [selectWidth-1:0] ALUSelect,
    output logic [addrWidth-1:0]   issueRd,
    input  logic                   wbValid,
    input  logic [addrWidth-1:0]   wbAddr,
    input  logic [dataWidth-1:0]   wbData
);

    logic [dataWidth-1:0] rs1_dat;
    logic [dataWidth-1:0] rs2_dat;
    logic [regCount-1:0]  busy;
    logic [regCount-1:0]  busy_nxt;
    logic                 rs1_stall;
    logic                 rs2_stall;
    logic                 rd_stall;
    logic                 hazard;
    logic                 accept;

    register_file #(
        .dataWidth (dataWidth),
        .regCount  (regCount),
        .addrWidth (addrWidth)
    ) u_register_file (
        .clk     (clk),
        .reset   (reset),
        .rs1Addr (rs1Addr),
        .rs2Addr (rs2Addr),
        .rs1Data (rs1_dat),
        .rs2Data (rs2_dat),
        .wbValid (wbValid),
        .wbAddr  (wbAddr),
        .wbData  (wbData)
    );

    // A register being written back this cycle is no longer pending for this check.
    always_comb begin
        rs1_stall = busy[rs1Addr] && !(wbValid && wbAddr == rs1Addr);
        rs2_stall = !useImm && busy[rs2Addr] && !(wbValid && wbAddr == rs2Addr);
        rd_stall  = (rdAddr != '0) && busy[rdAddr] && !(wbValid && wbAddr == rdAddr);
        hazard    = rs1_stall || rs2_stall || rd_stall;
    end

    assign instReady = (!issueValid || issueReady) && !hazard;
    assign accept    = instValid && instReady;

    // Set after clear so a same-cycle accept keeps the register pending.
    always_comb begin
        busy_nxt = busy;
        if (wbValid) begin
            busy_nxt[wbAddr] = 1'b0;
        end
        if (accept && rdAddr != '0) begin
            busy_nxt[rdAddr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issueValid <= 1'b0;
            inputA     <= '0;
            inputB     <= '0;
            ALUSelect  <= selectWidth'(ADD);
            issueRd    <= '0;
        end else if (accept) begin
            issueValid <= 1'b1;
            inputA     <= rs1_dat;
            inputB     <= useImm ? immediate : rs2_dat;
            ALUSelect  <= opSelect;
            issueRd    <= rdAddr;
        end else if (issueReady) begin
            issueValid <= 1'b0;
        end
    end

endmodule
